// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream round-robin packet arbiter.
package axis_arb_pkg;

  localparam int PKT_COUNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping modulo NUM_SOURCES.
module rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int IDX_W       = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   found,
  output logic [IDX_W-1:0]       idx
);

  localparam int unsigned N = NUM_SOURCES;

  int unsigned w_cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = 32'(ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!found && req[IDX_W'(w_cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin packet arbiter: locks one stream source per packet onto the shared output.
// Per-source completed-packet counters exist only when AXIS_ARB_PKT_COUNT_EN is defined.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [NUM_SOURCES-1:0][PARALLELISM-1:0][DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SOURCES-1:0]                                 s_valid,
  input  logic [NUM_SOURCES-1:0]                                 s_last,
  output logic [NUM_SOURCES-1:0]                                 s_ready,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]                 m_data,
  output logic                                                   m_valid,
  output logic                                                   m_last,
  input  logic                                                   m_ready,
  output logic [$clog2(NUM_SOURCES)-1:0]                         grant,
  output logic                                                   busy,
  output logic [NUM_SOURCES-1:0][PKT_COUNT_W-1:0]                pkt_count
);

  localparam int IDX_W = $clog2(NUM_SOURCES);

  state_t           r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_ptr;

  logic             w_lock;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic             w_xfer_last;

  rr_picker #(
    .NUM_SOURCES (NUM_SOURCES),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req   (s_valid),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // Output path is a pure mux of the locked source; data is forced to zero when not valid.
  assign w_lock      = (r_state == LOCK);
  assign m_valid     = w_lock & s_valid[r_grant];
  assign m_last      = w_lock & s_last[r_grant];
  assign m_data      = m_valid ? s_data[r_grant] : '0;
  assign s_ready     = w_lock ? (NUM_SOURCES'(m_ready) << r_grant) : '0;
  assign busy        = w_lock;
  assign grant       = r_grant;
  assign w_xfer_last = m_valid & m_ready & m_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_idx;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          if (w_xfer_last) begin
            r_state <= IDLE;
            r_ptr   <= (r_grant == IDX_W'(NUM_SOURCES - 1)) ? '0 : r_grant + IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_ARB_PKT_COUNT_EN
  logic [NUM_SOURCES-1:0][PKT_COUNT_W-1:0] r_pkt_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count <= '0;
    end else if (w_xfer_last && (r_pkt_count[r_grant] != '1)) begin
      r_pkt_count[r_grant] <= r_pkt_count[r_grant] + PKT_COUNT_W'(1);
    end
  end

  assign pkt_count = r_pkt_count;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: transaction-level reference model,
// per-source beat-order scoreboard, directed scenarios and randomized traffic.
module tb_axis_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int PL = 4;
  localparam int GW = $clog2(NS);
  localparam int CW = PL * DW;

`ifdef AXIS_ARB_PKT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NS-1:0][PL-1:0][DW-1:0]  s_data;
  logic [NS-1:0]                  s_valid;
  logic [NS-1:0]                  s_last;
  logic [NS-1:0]                  s_ready;
  logic [PL-1:0][DW-1:0]          m_data;
  logic                           m_valid;
  logic                           m_last;
  logic                           m_ready;
  logic [GW-1:0]                  grant;
  logic                           busy;
  logic [NS-1:0][15:0]            pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  axis_rr_arbiter #(
    .NUM_SOURCES (NS),
    .DATA_WIDTH  (DW),
    .PARALLELISM (PL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] enc(input int src, input int p, input int b, input int lane);
    return {8'(src), 8'(p), 8'(b), 8'(lane)};
  endfunction

  function automatic logic [CW-1:0] beat_word(input int src, input int p, input int b);
    logic [CW-1:0] w;
    w = '0;
    for (int j = 0; j < PL; j++) w[j*DW +: DW] = enc(src, p, b, j);
    return w;
  endfunction

  // ---------------- source drivers ----------------
  int rem[NS]      = '{default: 0};
  int len[NS]      = '{default: 1};
  int beat[NS]     = '{default: 0};
  int pkt[NS]      = '{default: 0};
  int gap_beat[NS] = '{default: -1};
  int gap_left[NS] = '{default: 0};
  int vprob    = 100;
  int rdy_mode = 0;
  int fixlen   = 0;
  int cyc      = 0;
  bit rst_req  = 1'b1;
  logic [NS-1:0] rdy_seen;

  always @(negedge clk) rdy_seen = s_ready;

  function automatic int newlen();
    return (fixlen > 0) ? fixlen : int'($urandom_range(5, 1));
  endfunction

  function automatic int any_rem();
    int a;
    a = 0;
    for (int i = 0; i < NS; i++) if (rem[i] > 0) a = 1;
    return a;
  endfunction

  task automatic cfg(input int i, input int n, input int l);
    rem[i]  = n;
    len[i]  = l;
    beat[i] = 0;
  endtask

  task automatic drive();
    bit act;
    rst = rst_req;
    for (int i = 0; i < NS; i++) begin
      act = (rem[i] > 0) && (int'($urandom_range(99, 0)) < vprob);
      if (act && gap_beat[i] == beat[i] && gap_left[i] > 0) begin
        act = 1'b0;
        gap_left[i]--;
      end
      if (act) begin
        s_valid[i] = 1'b1;
        s_last[i]  = (beat[i] == len[i] - 1);
        s_data[i]  = beat_word(i, pkt[i], beat[i]);
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'($urandom);
        s_data[i]  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 2) == 0;
      default: m_ready = 1'($urandom);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (rst) begin
        beat[i] = 0;
        pkt[i]  = 0;
      end else if (s_valid[i] && rdy_seen[i]) begin
        if (s_last[i]) begin
          beat[i] = 0;
          pkt[i]++;
          rem[i]--;
          len[i] = newlen();
        end else begin
          beat[i]++;
        end
      end
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    for (int i = 0; i < NS; i++) begin
      rem[i]      = 0;
      gap_left[i] = 0;
      gap_beat[i] = -1;
    end
    tick();
    tick();
    rst_req = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int k;
    k = 0;
    while (any_rem() != 0 && k < bound) begin
      tick();
      k++;
    end
    chk({"drain_", name}, CW'(any_rem()), CW'(0));
    tick();
    tick();
  endtask

  // ---------------- reference model + scoreboard ----------------
  int m_owner = -1, m_lastg = 0, m_ptr = 0;
  int m_cnt[NS] = '{default: 0};
  bit m_known = 1'b0;
  int n_owner = -1, n_lastg = 0, n_ptr = 0;
  int n_cnt[NS] = '{default: 0};
  bit n_known = 1'b0;
  int sb_pkt[NS]   = '{default: 0};
  int sb_beat[NS]  = '{default: 0};
  int sb_beats[NS] = '{default: 0};

  always @(negedge clk) begin
    logic [CW-1:0] e_data;
    logic          e_valid;
    logic [NS-1:0] e_ready;
    n_owner = m_owner;
    n_lastg = m_lastg;
    n_ptr   = m_ptr;
    n_cnt   = m_cnt;
    n_known = m_known;
    if (m_known) begin
      if (m_owner < 0) begin
        e_valid = 1'b0;
        e_ready = '0;
        e_data  = '0;
      end else begin
        e_valid = s_valid[m_owner];
        e_data  = e_valid ? CW'(s_data[m_owner]) : '0;
        e_ready = NS'(m_ready) << m_owner;
        chk("m_last", CW'(m_last), CW'(s_last[m_owner]));
      end
      chk("busy",    CW'(busy),    CW'(m_owner >= 0));
      chk("m_valid", CW'(m_valid), CW'(e_valid));
      chk("m_data",  CW'(m_data),  e_data);
      chk("s_ready", CW'(s_ready), CW'(e_ready));
      chk("grant",   CW'(grant),   CW'((m_owner >= 0) ? m_owner : m_lastg));
      for (int i = 0; i < NS; i++)
        chk("pkt_count", CW'(pkt_count[i]), CW'(CNT_EN ? m_cnt[i] : 0));

      if (!rst && e_valid && m_ready) begin
        chk("sb_order", CW'(m_data), beat_word(m_owner, sb_pkt[m_owner] % 256, sb_beat[m_owner]));
        sb_beats[m_owner]++;
        if (s_last[m_owner]) begin
          sb_pkt[m_owner]++;
          sb_beat[m_owner] = 0;
        end else begin
          sb_beat[m_owner]++;
        end
      end

      if (m_owner < 0) begin
        for (int k = 0; k < NS; k++)
          if (n_owner < 0 && s_valid[(m_ptr + k) % NS]) begin
            n_owner = (m_ptr + k) % NS;
            n_lastg = n_owner;
          end
      end else if (e_valid && m_ready && s_last[m_owner]) begin
        n_cnt[m_owner] = (m_cnt[m_owner] < 65535) ? m_cnt[m_owner] + 1 : 65535;
        n_ptr   = (m_owner + 1) % NS;
        n_owner = -1;
      end
    end
    if (rst) begin
      n_owner = -1;
      n_lastg = 0;
      n_ptr   = 0;
      n_cnt   = '{default: 0};
      n_known = 1'b1;
      for (int i = 0; i < NS; i++) begin
        sb_pkt[i]  = 0;
        sb_beat[i] = 0;
      end
    end
  end

  always @(posedge clk) begin
    m_owner = n_owner;
    m_lastg = n_lastg;
    m_ptr   = n_ptr;
    m_cnt   = n_cnt;
    m_known = n_known;
  end

  // ---------------- directed + random scenarios ----------------
  logic [DW-1:0] solo_exp[3];
  int base;

  initial begin
    solo_exp[0] = 32'h0200_0000;
    solo_exp[1] = 32'h0200_0100;
    solo_exp[2] = 32'h0200_0200;
    rst = 1'b1; m_ready = 1'b0; s_valid = '0; s_last = '0; s_data = '0;
    tick(); tick(); tick();

    // solo source 2, 3 beats
    rst_req = 1'b0; fixlen = 3; cfg(2, 1, 3);
    tick();
    @(negedge clk);
    chk("solo_idle_busy",  CW'(busy),    CW'(0));
    chk("solo_idle_valid", CW'(m_valid), CW'(0));
    for (int b = 0; b < 3; b++) begin
      tick();
      @(negedge clk);
      chk("solo_grant", CW'(grant),     CW'(2));
      chk("solo_busy",  CW'(busy),      CW'(1));
      chk("solo_data",  CW'(m_data[0]), CW'(solo_exp[b]));
    end

    // wrap from ptr=3 with single-beat packets on sources 0 and 3
    fixlen = 1; cfg(0, 1, 1); cfg(3, 1, 1);
    tick(); @(negedge clk);
    chk("solo_end_busy", CW'(busy),         CW'(0));
    chk("solo_hold",     CW'(grant),        CW'(2));
    chk("solo_count",    CW'(pkt_count[2]), CW'(CNT_EN ? 1 : 0));
    tick(); @(negedge clk);
    chk("wrap_grant3", CW'(grant),  CW'(3));
    chk("wrap_last3",  CW'(m_last), CW'(1));
    tick(); @(negedge clk);
    chk("wrap_idle1",  CW'(busy),   CW'(0));
    tick(); @(negedge clk);
    chk("wrap_grant0", CW'(grant),  CW'(0));
    chk("wrap_busy0",  CW'(busy),   CW'(1));
    tick(); @(negedge clk);
    chk("wrap_idle2",  CW'(busy),   CW'(0));

    // fairness: four sources, two 2-beat packets each
    do_reset();
    fixlen = 2;
    for (int i = 0; i < NS; i++) cfg(i, 2, 2);
    tick();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("fair_busy", CW'(busy), CW'((k % 3) != 0));
      if ((k % 3) != 0) chk("fair_grant", CW'(grant), CW'((k / 3) % 4));
      tick();
    end
    @(negedge clk);
    chk("fair_end_busy", CW'(busy), CW'(0));
    for (int i = 0; i < NS; i++) chk("fair_count", CW'(pkt_count[i]), CW'(CNT_EN ? 2 : 0));

    // reset on beat 2 of a 4-beat packet
    fixlen = 4; cfg(2, 1, 4);
    tick(); @(negedge clk);
    chk("rst_pre_count", CW'(pkt_count[0]), CW'(CNT_EN ? 2 : 0));
    tick(); @(negedge clk);
    chk("rst_grant2", CW'(grant), CW'(2));
    rst_req = 1'b1;
    tick(); @(negedge clk);
    chk("rst_beat2_busy", CW'(busy), CW'(1));
    rst_req = 1'b0; cfg(0, 1, 4);
    tick(); @(negedge clk);
    chk("rst_busy",    CW'(busy),      CW'(0));
    chk("rst_valid",   CW'(m_valid),   CW'(0));
    chk("rst_s_ready", CW'(s_ready),   CW'(0));
    chk("rst_grant",   CW'(grant),     CW'(0));
    chk("rst_counts",  CW'(pkt_count), CW'(0));
    tick(); @(negedge clk);
    chk("rst_new_grant", CW'(grant), CW'(0));
    chk("rst_new_busy",  CW'(busy),  CW'(1));
    drain("rst", 200);

    // mid-packet valid gap on source 0 while source 3 waits
    do_reset();
    fixlen = 2; cfg(0, 1, 5); cfg(3, 1, 2);
    gap_beat[0] = 2; gap_left[0] = 2;
    tick();
    for (int k = 0; k < 40 && rem[0] > 0; k++) begin
      @(negedge clk);
      chk("gap_grant", CW'(grant), CW'(0));
      if (k > 0) chk("gap_busy", CW'(busy), CW'(1));
      tick();
    end
    chk("gap_done", CW'(rem[0]), CW'(0));
    drain("gap", 100);
    gap_beat[0] = -1;

    // backpressure: source 1, 4 beats, m_ready toggling
    base = sb_beats[1];
    fixlen = 4; rdy_mode = 1; cfg(1, 1, 4);
    drain("bp", 100);
    chk("bp_beats", CW'(sb_beats[1] - base), CW'(4));
    rdy_mode = 0;

    // randomized traffic
    vprob = 75; rdy_mode = 2; fixlen = 0;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NS; i++) cfg(i, int'($urandom_range(4, 1)), int'($urandom_range(5, 1)));
      drain("rand", 2000);
    end
    for (int i = 0; i < NS; i++) chk("sb_pkts", CW'(sb_pkt[i]), CW'(pkt[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
